// File: rtl/rv_pipe_pkg.sv
// Shared RV32I pipeline definitions: hazard FSM states and architectural constants.
package rv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } hz_state_e;

  localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/hazard_watchdog.sv
// Data-memory wait watchdog: saturating counter of consecutive wait cycles plus a
// sticky timeout flag that only rst clears.
module hazard_watchdog #(
  parameter int MEM_WAIT_MAX = 255,
  parameter int WD_W         = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic timeout
);

  localparam logic [WD_W-1:0] MAX = WD_W'(MEM_WAIT_MAX);

  logic [WD_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (inc && cnt != MAX)
        cnt <= cnt + 1'b1;
      // Flag is set on the same edge that lands the count on MAX.
      if (inc && cnt == MAX - 1'b1)
        timeout <= 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline. Optional perf counters are built
// when HAZARD_PERF_EN is defined; otherwise the perf ports read zero.
module hazard_ctrl
  import rv_pipe_pkg::*;
#(
  parameter int MEM_WAIT_MAX = 255,
  parameter int WD_W         = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  d_rs1,
  input  logic [4:0]  d_rs2,
  input  logic        d_rs1_used,
  input  logic        d_rs2_used,
  input  logic [4:0]  e_rd,
  input  logic        e_is_load,
  input  logic        e_reg_write,
  input  logic        e_is_div,
  input  logic        e_jb,
  input  logic        imem_wait,
  input  logic        dmem_wait,
  input  logic        div_done,
  output logic        stall_f,
  output logic        stall_d,
  output logic        flush_d,
  output logic        bubble_e,
  output logic        hold_em,
  output logic        wb_kill,
  output logic        div_start,
  output logic        mem_timeout,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
);

  hz_state_e state, state_nxt;
  logic      div_issued;
  logic      load_use, div_go, flush_ev;

  assign load_use = e_is_load & e_reg_write & (e_rd != REG_X0) &
                    ((d_rs1_used & (d_rs1 == e_rd)) | (d_rs2_used & (d_rs2 == e_rd)));
  assign div_go   = e_is_div & ~div_issued;
  assign flush_ev = ~rst & (state == RUN) & ~dmem_wait & e_jb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // Outputs are gated by rst so an asynchronous reset silences them immediately.
  always_comb begin
    state_nxt = state;
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    bubble_e  = 1'b0;
    hold_em   = 1'b0;
    wb_kill   = 1'b0;
    div_start = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (dmem_wait) begin
            {stall_f, stall_d, hold_em, wb_kill} = 4'b1111;
            state_nxt = MEM_WAIT;
          end else if (e_jb) begin
            {flush_d, bubble_e} = 2'b11;
          end else if (div_go) begin
            {stall_f, stall_d, hold_em, wb_kill, div_start} = 5'b11111;
            state_nxt = DIV_WAIT;
          end else if (load_use) begin
            {stall_f, stall_d, bubble_e} = 3'b111;
          end else if (imem_wait) begin
            {stall_f, flush_d} = 2'b11;
          end
        end
        MEM_WAIT: begin
          if (dmem_wait) {stall_f, stall_d, hold_em, wb_kill} = 4'b1111;
          else           state_nxt = RUN;
        end
        DIV_WAIT: begin
          if (div_done) state_nxt = RUN;
          else          {stall_f, stall_d, hold_em, wb_kill} = 4'b1111;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Masks the completed divide still sitting in E until E moves on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                div_issued <= 1'b0;
    else if (state == DIV_WAIT && div_done) div_issued <= 1'b1;
    else if (state == RUN && !hold_em)      div_issued <= 1'b0;
  end

  hazard_watchdog #(
    .MEM_WAIT_MAX(MEM_WAIT_MAX),
    .WD_W        (WD_W)
  ) u_wd (
    .clk    (clk),
    .rst    (rst),
    .inc    (state == MEM_WAIT && dmem_wait),
    .clr    (state == MEM_WAIT && !dmem_wait),
    .timeout(mem_timeout)
  );

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (stall_f)  perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush_ev) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`else
  logic unused_perf;
  assign unused_perf    = flush_ev;
  assign perf_stall_cnt = 32'd0;
  assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational RUN-state vector table plus
// multi-cycle sequences for divide, memory wait/watchdog and reset.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  d_rs1, d_rs2, e_rd;
  logic        d_rs1_used, d_rs2_used, e_is_load, e_reg_write, e_is_div, e_jb;
  logic        imem_wait, dmem_wait, div_done;
  logic        stall_f, stall_d, flush_d, bubble_e, hold_em, wb_kill, div_start;
  logic        mem_timeout;
  logic [31:0] perf_stall_cnt, perf_flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rs1_used(d_rs1_used), .d_rs2_used(d_rs2_used),
    .e_rd(e_rd), .e_is_load(e_is_load), .e_reg_write(e_reg_write), .e_is_div(e_is_div),
    .e_jb(e_jb), .imem_wait(imem_wait), .dmem_wait(dmem_wait), .div_done(div_done),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .bubble_e(bubble_e),
    .hold_em(hold_em), .wb_kill(wb_kill), .div_start(div_start),
    .mem_timeout(mem_timeout), .perf_stall_cnt(perf_stall_cnt),
    .perf_flush_cnt(perf_flush_cnt)
  );

  always #5 clk = ~clk;

  // Output bit order: stall_f stall_d flush_d bubble_e hold_em wb_kill div_start
  localparam logic [6:0] O_NONE = 7'b0000000;
  localparam logic [6:0] O_LU   = 7'b1101000;
  localparam logic [6:0] O_JB   = 7'b0011000;
  localparam logic [6:0] O_IMEM = 7'b1010000;
  localparam logic [6:0] O_DIV  = 7'b1100111;
  localparam logic [6:0] O_HOLD = 7'b1100110;

  typedef struct {
    string      name;
    logic [4:0] rs1, rs2, rd;
    logic       u1, u2, ld, rw, dv, jb, im, dm;
    logic [6:0] exp;
  } vec_t;

  vec_t vq[$];

  function automatic logic [6:0] outs();
    return {stall_f, stall_d, flush_d, bubble_e, hold_em, wb_kill, div_start};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_in();
    d_rs1 = 0; d_rs2 = 0; e_rd = 0; d_rs1_used = 0; d_rs2_used = 0;
    e_is_load = 0; e_reg_write = 0; e_is_div = 0; e_jb = 0;
    imem_wait = 0; dmem_wait = 0; div_done = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_in();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    clear_in();
    //          name          rs1 rs2 rd  u1 u2 ld rw dv jb im dm exp
    vq.push_back('{"idle",      5'd0, 5'd0, 5'd0, 0,0,0,0,0,0,0,0, O_NONE});
    vq.push_back('{"lu_rs1",    5'd5, 5'd1, 5'd5, 1,1,1,1,0,0,0,0, O_LU});
    vq.push_back('{"lu_x0",     5'd0, 5'd1, 5'd0, 1,1,1,1,0,0,0,0, O_NONE});
    vq.push_back('{"lu_unused", 5'd5, 5'd1, 5'd5, 0,1,1,1,0,0,0,0, O_NONE});
    vq.push_back('{"lu_rs2",    5'd3, 5'd9, 5'd9, 1,1,1,1,0,0,0,0, O_LU});
    vq.push_back('{"lu_nowr",   5'd5, 5'd1, 5'd5, 1,1,1,0,0,0,0,0, O_NONE});
    vq.push_back('{"alu_dep",   5'd5, 5'd1, 5'd5, 1,1,0,1,0,0,0,0, O_NONE});
    vq.push_back('{"jb_lu",     5'd5, 5'd1, 5'd5, 1,1,1,1,0,1,0,0, O_JB});
    vq.push_back('{"imem",      5'd0, 5'd0, 5'd0, 0,0,0,0,0,0,1,0, O_IMEM});
    vq.push_back('{"lu_imem",   5'd5, 5'd1, 5'd5, 1,1,1,1,0,0,1,0, O_LU});
    vq.push_back('{"div",       5'd0, 5'd0, 5'd0, 0,0,0,0,1,0,0,0, O_DIV});
    vq.push_back('{"dmem",      5'd0, 5'd0, 5'd0, 0,0,0,0,0,0,0,1, O_HOLD});
    vq.push_back('{"dmem_all",  5'd5, 5'd1, 5'd5, 1,1,1,1,1,1,1,1, O_HOLD});
    vq.push_back('{"jb_div",    5'd0, 5'd0, 5'd0, 0,0,0,0,1,1,0,0, O_JB});
    vq.push_back('{"div_lu",    5'd5, 5'd1, 5'd5, 1,1,1,1,1,0,0,0, O_DIV});

    // Reset state
    #2;
    chk("rst_outs", 32'(outs()), 32'(O_NONE));
    chk("rst_timeout", 32'(mem_timeout), 32'd0);
    chk("rst_perf_stall", perf_stall_cnt, 32'd0);
    chk("rst_perf_flush", perf_flush_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table: each vector evaluated in RUN, reset pulsed before any clock edge.
    foreach (vq[i]) begin
      @(negedge clk);
      d_rs1 = vq[i].rs1; d_rs2 = vq[i].rs2; e_rd = vq[i].rd;
      d_rs1_used = vq[i].u1; d_rs2_used = vq[i].u2;
      e_is_load = vq[i].ld; e_reg_write = vq[i].rw; e_is_div = vq[i].dv;
      e_jb = vq[i].jb; imem_wait = vq[i].im; dmem_wait = vq[i].dm;
      #1;
      chk(vq[i].name, 32'(outs()), 32'(vq[i].exp));
      rst = 1'b1; #1; rst = 1'b0;
      clear_in();
    end

    // Load-use stalls one cycle; next cycle E holds the bubble.
    do_reset();
    d_rs1 = 5'd5; e_rd = 5'd5; d_rs1_used = 1; e_is_load = 1; e_reg_write = 1;
    #1 chk("seq_lu_c0", 32'(outs()), 32'(O_LU));
    @(negedge clk);
    e_is_load = 0; e_reg_write = 0; e_rd = 0;
    #1 chk("seq_lu_c1", 32'(outs()), 32'(O_NONE));

    // Redirect with concurrent load-use: one flush, no stall counted.
    do_reset();
    d_rs1 = 5'd5; e_rd = 5'd5; d_rs1_used = 1; e_is_load = 1; e_reg_write = 1; e_jb = 1;
    #1 chk("seq_jb", 32'(outs()), 32'(O_JB));
    @(negedge clk);
    clear_in();
`ifdef HAZARD_PERF_EN
    chk("perf_flush_1", perf_flush_cnt, 32'd1);
    chk("perf_stall_0", perf_stall_cnt, 32'd0);
`else
    chk("perf_flush_off", perf_flush_cnt, 32'd0);
    chk("perf_stall_off", perf_stall_cnt, 32'd0);
`endif

    // Divide: launch, 32 hold cycles (dmem_wait mid-way ignored), done, masked, relaunch.
    do_reset();
    e_is_div = 1;
    #1 chk("div_launch", 32'(outs()), 32'(O_DIV));
    for (int c = 1; c < 33; c++) begin
      @(negedge clk);
      dmem_wait = (c == 10);
      #1 chk($sformatf("div_hold%0d", c), 32'(outs()), 32'(O_HOLD));
    end
    @(negedge clk);
    dmem_wait = 0; div_done = 1;
    #1 chk("div_done", 32'(outs()), 32'(O_NONE));
    @(negedge clk);
    div_done = 0;
    #1 chk("div_masked", 32'(outs()), 32'(O_NONE));
    @(negedge clk);
    #1 chk("div_relaunch", 32'(outs()), 32'(O_DIV));
`ifdef HAZARD_PERF_EN
    @(negedge clk);
    e_is_div = 0;
    // 1 launch + 32 holds + 1 relaunch
    chk("perf_stall_div", perf_stall_cnt, 32'd34);
`endif

    // Memory wait held 300 cycles: watchdog trips near 255, stays after release.
    do_reset();
    dmem_wait = 1;
    repeat (250) @(negedge clk);
    chk("wd_early", 32'(mem_timeout), 32'd0);
    chk("wd_hold", 32'(outs()), 32'(O_HOLD));
    repeat (10) @(negedge clk);
    chk("wd_trip", 32'(mem_timeout), 32'd1);
    repeat (40) @(negedge clk);
    dmem_wait = 0; e_jb = 1;
    #1 chk("mem_release", 32'(outs()), 32'(O_NONE));
    @(negedge clk);
    #1 chk("post_mem_jb", 32'(outs()), 32'(O_JB));
    chk("wd_sticky", 32'(mem_timeout), 32'd1);
    e_jb = 0;
    @(negedge clk);
    rst = 1'b1;
    #1 chk("wd_rst_clr", 32'(mem_timeout), 32'd0);
    rst = 1'b0;

    // Async reset inside DIV_WAIT with e_is_div still asserted.
    do_reset();
    e_is_div = 1;
    @(negedge clk);
    @(negedge clk);
    #1 chk("pre_rst_hold", 32'(outs()), 32'(O_HOLD));
    #2 rst = 1'b1;
    #1 chk("rst_async", 32'(outs()), 32'(O_NONE));
    e_is_div = 0;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("post_rst_idle", 32'(outs()), 32'(O_NONE));
    @(negedge clk);
    e_is_div = 1;
    #1 chk("post_rst_div", 32'(outs()), 32'(O_DIV));
    @(negedge clk);
    clear_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
